// File: rtl/sram_pkg.sv
// Shared widths, port indices and request/response records for the SRAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;

    localparam int PORT_IFETCH = 0;
    localparam int PORT_LSU    = 1;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } rsp_t;

    // Addresses at or beyond DEPTH must never touch the array.
    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return addr < ADDR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a one-bit record of the last winner.
// Latency: grant is combinational in the request cycle; history updates on the closing edge.
// Backpressure: the losing requester simply sees no grant and holds its request.
module rr_arb2 (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    typedef enum logic {
        LAST0 = 1'b0,
        LAST1 = 1'b1
    } rr_state_t;

    rr_state_t state_q;
    rr_state_t state_d;
    logic      win;

    // Remember who won last; reset to LAST1 so port 0 takes the first tie.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= LAST1;
        end else begin
            state_q <= state_d;
        end
    end

    // Pick the winner: a lone requester wins, a tie goes to the port that did not win last.
    always_comb begin
        gnt     = 2'b00;
        win     = 1'b0;
        state_d = state_q;
        if (Rst_n) begin
            if (req[0] && req[1]) begin
                win = (state_q == LAST0);
            end else begin
                win = req[1];
            end
            if (|req) begin
                gnt     = win ? 2'b10 : 2'b01;
                state_d = rr_state_t'(win);
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between instruction fetch (port 0) and load/store (port 1).
// Latency: request accepted combinationally, response pulse registered exactly one cycle later.
// Backpressure: one ready per cycle; a requester holds its fields until it sees ready.
module sram_port_arbiter
    import sram_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_inputData,
    output logic              sram_writeEnable,
    input  logic [DATA_W-1:0] sram_outputData
);

    req_t              req [2];
    req_t              sel;
    rsp_t              rsp_q [2];
    logic [1:0]        gnt;
    logic              sel_ok;
    logic [DATA_W-1:0] rd_val;

    assign req[PORT_IFETCH] = '{valid: req0_valid, write: req0_write, addr: req0_addr, wdata: req0_wdata};
    assign req[PORT_LSU]    = '{valid: req1_valid, write: req1_write, addr: req1_addr, wdata: req1_wdata};

    rr_arb2 u_arb (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .req   ({req1_valid, req0_valid}),
        .gnt   (gnt)
    );

    assign req0_ready = gnt[PORT_IFETCH];
    assign req1_ready = gnt[PORT_LSU];

    // Route the granted request to the SRAM; everything is zero when nobody is granted
    // (which also covers reset, since the arbiter grants nothing then).
    always_comb begin
        sel = '0;
        if (gnt[PORT_IFETCH]) begin
            sel = req[PORT_IFETCH];
        end else if (gnt[PORT_LSU]) begin
            sel = req[PORT_LSU];
        end
    end

    assign sel_ok           = in_range(sel.addr);
    assign sram_address     = sel.addr;
    assign sram_inputData   = sel.wdata;
    assign sram_writeEnable = sel.valid & sel.write & sel_ok;

    // Combinational SRAM read data is captured before the write lands; only one port is
    // granted, so a read and a write never share a cycle.
    assign rd_val = (!sel.write && sel_ok) ? sram_outputData : '0;

    // Register the response for the granted port; the other port's pulse drops while its
    // data and error fields hold.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rsp_q[0] <= '0;
            rsp_q[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rsp_q[p].valid <= gnt[p];
                if (gnt[p]) begin
                    rsp_q[p].err   <= !sel_ok;
                    rsp_q[p].rdata <= rd_val;
                end
            end
        end
    end

    assign rsp0_valid = rsp_q[PORT_IFETCH].valid;
    assign rsp0_rdata = rsp_q[PORT_IFETCH].rdata;
    assign rsp0_err   = rsp_q[PORT_IFETCH].err;
    assign rsp1_valid = rsp_q[PORT_LSU].valid;
    assign rsp1_rdata = rsp_q[PORT_LSU].rdata;
    assign rsp1_err   = rsp_q[PORT_LSU].err;

endmodule
